checksum_scheduler: RTL and testbench



---
 rtl/checksum_scheduler_pkg.sv | 42 ++++
 rtl/checksum_scheduler_rr_arbiter.sv | 68 ++++++
 rtl/checksum_scheduler.sv | 132 +++++++++++++
 tb/tb_checksum_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checksum_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : checksum_scheduler_pkg
// Purpose  : Shared types for the checksum scheduler: flit layout, checksum
//            operation encoding, the result bundle and the combinational
//            checksum function used by every checksum consumer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package checksum_scheduler_pkg;

    localparam int DEFAULT_CHKSUM_REQ = 4;

    // Flit layout: 8-bit header, 16-bit payload, 8-bit checksum.
    typedef struct packed {
        logic [7:0]  header;
        logic [15:0] payload;
        logic [7:0]  checksum;
    } flit_t;

    typedef enum logic {
        CS_GENERATE = 1'b0,
        CS_CHECK    = 1'b1
    } checksum_op_t;

    typedef struct packed {
        flit_t        flit;
        logic         ok;
        checksum_op_t op;
    } checksum_result_t;

    // One's complement of the modulo-256 byte sum over header and payload.
    // The checksum field itself is excluded, so GENERATE and CHECK share it.
    function automatic logic [7:0] calculate_checksum_comb(input flit_t f);
        logic [7:0] sum;
        sum = f.header + f.payload[15:8] + f.payload[7:0];
        return ~sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/checksum_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter. Grants the first asserted request at or
//            above the priority pointer (wrapping). The pointer moves to one
//            past the granted index only when the owner strobes advance.
// Ports    : clk, rst_n      - clock, async active-low reset
//            req            - request vector
//            advance        - a grant was consumed this cycle
//            adv_idx        - index that was consumed
//            grant          - one-hot grant (zero when no request)
//            grant_idx      - binary index of the grant
//            grant_any      - at least one request is granted
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [SRC_W-1:0]   adv_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               grant_any
);

    localparam logic [SRC_W-1:0] c_LAST_IDX = SRC_W'(NUM_REQ - 1);

    logic [SRC_W-1:0] r_ptr;

    // Scan NUM_REQ positions starting at r_ptr; wrap done explicitly so a
    // non-power-of-two NUM_REQ never produces an out-of-range index.
    always_comb begin
        int               j;
        logic [SRC_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = SRC_W'(j);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (adv_idx == c_LAST_IDX) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/checksum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : checksum_scheduler
// Purpose  : Time-shares one combinational checksum unit between NUM_REQ
//            flit requesters (GENERATE or CHECK), round-robin, into a single
//            registered valid/ready output stage. Counts CHECK failures.
// Ports    : clk, rst_n        - clock, async active-low reset
//            req_valid/ready  - per-requester handshake (ready one-hot/zero)
//            req_flit         - per-requester flit
//            req_check        - 1 = CHECK, 0 = GENERATE
//            out_valid/ready  - result handshake
//            out_flit         - flit with checksum field = computed checksum
//            out_ok           - CHECK: received == computed; GENERATE: 1
//            out_is_check     - op of the held result
//            out_src          - requester index of the held result
//            err_count        - saturating count of failed CHECKs
//            clear_err        - synchronous clear of err_count (wins)
// Revision : 1.0 - initial release
// ============================================================================
module checksum_scheduler
    import checksum_scheduler_pkg::*;
#(
    parameter int  NUM_REQ   = DEFAULT_CHKSUM_REQ,
    parameter int  ERR_CNT_W = 16,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  flit_t [NUM_REQ-1:0]  req_flit,
    input  logic [NUM_REQ-1:0]   req_check,
    output logic                 out_valid,
    input  logic                 out_ready,
    output flit_t                out_flit,
    output logic                 out_ok,
    output logic                 out_is_check,
    output logic [SRC_W-1:0]     out_src,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clear_err
);

    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = '1;

    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_grant_idx;
    logic               w_grant_any;
    logic               w_can_load;
    logic               w_transfer;
    flit_t              w_sel_flit;
    checksum_op_t       w_sel_op;
    logic [7:0]         w_csum;
    checksum_result_t   w_result;

    logic               r_out_valid;
    checksum_result_t   r_result;
    logic [SRC_W-1:0]   r_src;
    logic [ERR_CNT_W-1:0] r_err_count;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (w_transfer),
        .adv_idx   (w_grant_idx),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    // When the stage is empty, out_ready is masked out entirely.
    assign w_can_load = !r_out_valid || out_ready;
    assign w_transfer = rst_n && w_grant_any && w_can_load;
    assign req_ready  = rst_n ? (w_grant & {NUM_REQ{w_can_load}}) : '0;

    // Single checksum unit after the grant mux.
    always_comb begin
        w_sel_flit = req_flit[w_grant_idx];
        w_sel_op   = req_check[w_grant_idx] ? CS_CHECK : CS_GENERATE;
        w_csum     = calculate_checksum_comb(w_sel_flit);
        w_result   = '{flit: w_sel_flit, ok: 1'b1, op: w_sel_op};
        w_result.flit.checksum = w_csum;
        // == (not ===) so an X checksum propagates instead of reading as a miss
        if (w_sel_op == CS_CHECK) begin
            w_result.ok = (w_sel_flit.checksum == w_csum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_src       <= '0;
        end else if (w_transfer) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_src       <= w_grant_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (clear_err) begin
            r_err_count <= '0;
        end else if (w_transfer && (w_result.op == CS_CHECK) && !w_result.ok
                     && (r_err_count != c_ERR_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_flit     = r_result.flit;
    assign out_ok       = r_result.ok;
    assign out_is_check = (r_result.op == CS_CHECK);
    assign out_src      = r_src;
    assign err_count    = r_err_count;

    // Requesters must hold flit and op while waiting; dropping valid is allowed.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_stable
        a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[i] && !req_ready[i]) |=>
                (!req_valid[i] || ($stable(req_flit[i]) && $stable(req_check[i]))));
    end

endmodule

`default_nettype wire

// File: tb/tb_checksum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_checksum_scheduler
// Purpose  : Self-checking bench for checksum_scheduler with a transaction
//            level reference model (arithmetic checksum, integer pointer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_checksum_scheduler;
    import checksum_scheduler_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int ERR_CNT_W = 16;
    localparam int SRC_W     = 2;
    localparam int ERR_MAX   = 65535;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    flit_t [NUM_REQ-1:0]  req_flit;
    logic [NUM_REQ-1:0]   req_check;
    logic                 out_valid;
    logic                 out_ready;
    flit_t                out_flit;
    logic                 out_ok;
    logic                 out_is_check;
    logic [SRC_W-1:0]     out_src;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 clear_err;

    checksum_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .ERR_CNT_W    (ERR_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_flit     (req_flit),
        .req_check    (req_check),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_flit     (out_flit),
        .out_ok       (out_ok),
        .out_is_check (out_is_check),
        .out_src      (out_src),
        .err_count    (err_count),
        .clear_err    (clear_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit    m_valid;
    flit_t m_flit;
    bit    m_ok;
    bit    m_chk;
    int    m_src;
    int    m_ptr;
    int    m_err;
    bit    quiet;
    flit_t held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int golden(input int h, input int p);
        return 255 - ((h + (p / 256) + (p % 256)) % 256);
    endfunction

    function automatic flit_t make_flit(input int h, input int p, input int cs);
        flit_t f;
        f.header   = 8'(h);
        f.payload  = 16'(p);
        f.checksum = 8'(cs);
        return f;
    endfunction

    function automatic flit_t rand_flit(input bit good);
        int h, p, g;
        h = int'($urandom_range(0, 255));
        p = int'($urandom_range(0, 65535));
        g = golden(h, p);
        return make_flit(h, p, good ? g : (g + 1) % 256);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_flit = '0; m_ok = 0; m_chk = 0;
        m_src = 0; m_ptr = 0; m_err = 0;
    endtask

    task automatic compare_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("out_flit", out_flit, m_flit);
        chk("out_ok", out_ok, m_ok);
        chk("out_is_check", out_is_check, m_chk);
        chk("out_src", out_src, m_src);
        chk("err_count", err_count, m_err);
    endtask

    // One clock: predict grant from the model, check req_ready, clock, update
    // the model, compare outputs.
    task automatic cycle();
        int g, j, gold;
        bit cl, xfer, ordy, clr, c;
        logic [NUM_REQ-1:0] exp_rdy;
        flit_t f;
        #2;
        cl = !m_valid || out_ready;
        g  = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (m_ptr + k) % NUM_REQ;
            if (g < 0 && req_valid[j[SRC_W-1:0]]) g = j;
        end
        xfer    = (g >= 0) && cl;
        exp_rdy = xfer ? (NUM_REQ'(1) << g) : '0;
        if (!quiet) chk("req_ready", req_ready, exp_rdy);
        f = '0; c = 0;
        if (g >= 0) begin
            f = req_flit[g[SRC_W-1:0]];
            c = req_check[g[SRC_W-1:0]];
        end
        ordy = out_ready;
        clr  = clear_err;
        @(posedge clk);
        #1;
        if (xfer) begin
            gold = golden(int'(f.header), int'(f.payload));
            m_valid = 1;
            m_flit  = f;
            m_flit.checksum = 8'(gold);
            m_ok    = !c || (int'(f.checksum) == gold);
            m_chk   = c;
            m_src   = g;
            m_ptr   = (g + 1) % NUM_REQ;
            if (c && !m_ok && m_err < ERR_MAX) m_err++;
        end else if (ordy) begin
            m_valid = 0;
        end
        if (clr) m_err = 0;
        if (!quiet) compare_outputs();
    endtask

    initial begin
        model_reset();
        quiet     = 0;
        rst_n     = 1'b0;
        req_valid = '1;
        req_check = '0;
        req_flit  = '0;
        out_ready = 1'b0;
        clear_err = 1'b0;

        // Reset state
        #3;
        compare_outputs();
        chk("reset_ready", req_ready, '0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Single GENERATE on req0
        req_flit[0]  = make_flit('h12, 'h3456, 'hFF);
        req_check[0] = 1'b0;
        req_valid    = 4'b0001;
        out_ready    = 1'b1;
        cycle();
        chk("gen_checksum", out_flit.checksum, 8'h63);
        chk("gen_src", out_src, 0);
        chk("gen_ok", out_ok, 1);
        req_valid = '0;
        cycle();

        // CHECK mismatch then match on req2
        req_flit[2]  = rand_flit(1'b0);
        req_check[2] = 1'b1;
        req_valid    = 4'b0100;
        cycle();
        chk("chk_bad_ok", out_ok, 0);
        chk("chk_bad_is_check", out_is_check, 1);
        chk("chk_bad_err", err_count, 1);
        req_flit[2] = rand_flit(1'b1);
        cycle();
        chk("chk_good_ok", out_ok, 1);
        chk("chk_good_err", err_count, 1);
        req_valid = '0;

        // Bring the pointer back to 0 via req3
        req_flit[3]  = rand_flit(1'b1);
        req_check[3] = 1'b0;
        req_valid    = 4'b1000;
        cycle();
        req_valid = '0;
        cycle();

        // Round robin with all requesters valid, random ops/flits
        for (int i = 0; i < NUM_REQ; i++) begin
            req_flit[i]  = rand_flit(1'($urandom_range(0, 1)));
            req_check[i] = 1'($urandom_range(0, 1));
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_src", out_src, k % NUM_REQ);
            chk("rr_valid", out_valid, 1);
        end
        req_valid = '0;
        cycle();

        // Backpressure with req1 and req3
        req_flit[1]  = rand_flit(1'b1);
        req_flit[3]  = rand_flit(1'b0);
        req_check[1] = 1'b1;
        req_check[3] = 1'b1;
        req_valid    = 4'b1010;
        out_ready    = 1'b0;
        cycle();
        chk("bp_first_src", out_src, 1);
        held = out_flit;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_flit", out_flit, held);
            chk("bp_ready_zero", req_ready, '0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release_src3", out_src, 3);
        cycle();
        chk("bp_release_src1", out_src, 1);
        req_valid = '0;
        cycle();

        // Saturate the error counter, then clear against a failing CHECK
        req_flit[0]  = rand_flit(1'b0);
        req_check[0] = 1'b1;
        req_valid    = 4'b0001;
        quiet = 1;
        repeat (ERR_MAX + 4) cycle();
        quiet = 0;
        cycle();
        chk("err_saturated", err_count, 16'hFFFF);
        clear_err = 1'b1;
        cycle();
        chk("err_clear_priority", err_count, 0);
        clear_err = 1'b0;
        req_valid = '0;
        cycle();

        // Reset asserted while the output is stalled
        req_flit[0]  = rand_flit(1'b0);
        req_check[0] = 1'b1;
        req_valid    = 4'b0001;
        out_ready    = 1'b0;
        cycle();
        req_valid = '0;
        cycle();
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        req_valid = '1;
        #1;
        chk("reset_mid_ready", req_ready, '0);
        @(posedge clk); #1;
        compare_outputs();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("post_reset_src", out_src, 0);
        req_valid = '0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
